// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM download writer: FSM encodings and the buffered
// SDRAM word-write entry, plus the byte-address to port/word-address routing.
package rom_dl_pkg;

    typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DRAIN, L_DONE} loader_state_t;
    typedef enum logic {D_IDLE, D_WAIT} disp_state_t;

    typedef struct packed {
        logic        port2;
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } wr_entry_t;

    // Graphics words are addressed relative to the start of the graphics region.
    function automatic wr_entry_t make_entry(input logic [24:0] addr,
                                             input logic [24:0] gfx_base,
                                             input logic [1:0]  ds,
                                             input logic [15:0] d);
        wr_entry_t e;
        e.port2 = (addr >= gfx_base);
        e.a     = e.port2 ? (addr[23:1] - gfx_base[23:1]) : addr[23:1];
        e.ds    = ds;
        e.d     = d;
        return e;
    endfunction

endpackage

// File: rtl/dl_word_fifo.sv
// Word-write buffer: registered write, show-ahead read. A write while full is
// only taken when a read frees the head slot in the same cycle.
module dl_word_fifo
    import rom_dl_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic      clk_sys,
    input  logic      reset_n,
    input  logic      wr_en,
    input  wr_entry_t wr_data,
    input  logic      rd_en,
    output wr_entry_t rd_data,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    wr_entry_t  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_wr;
    logic        do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/rom_download_sdram_writer.sv
// Pairs ROM download bytes into 16-bit words, buffers them, and writes them to
// SDRAM port 1 (CPU ROM) or port 2 (graphics ROM); reports completion and core reset.
module rom_download_sdram_writer
    import rom_dl_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [24:0] GFX_BASE   = 25'h10000,
    parameter logic [7:0]  ROM_INDEX  = 8'h00
)(
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_downl,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ext_reset,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port1_we,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        port2_we,
    output logic        rom_loaded,
    output logic        core_reset,
    output logic        overflow,
    output logic [1:0]  dbg_loader_state,
    output logic        dbg_disp_state
);

    loader_state_t l_state;
    disp_state_t   d_state;
    logic          wr_d, downl_d;
    logic          index_ok, accept, dl_rise, dl_fall, flush, drained;
    logic          pend_valid;
    logic [24:0]   pend_addr;
    logic [7:0]    pend_lo;
    logic          push_valid, hold_valid, pair;
    wr_entry_t     push_entry, hold_entry, stale_e, new_e, head;
    logic          fifo_rd, fifo_full, fifo_empty, sel2, sel_idle;

    assign index_ok = (ioctl_index == ROM_INDEX);
    assign accept   = ioctl_wr && !wr_d && ioctl_downl && index_ok;
    assign dl_rise  = ioctl_downl && !downl_d && index_ok;
    assign dl_fall  = !ioctl_downl && downl_d;
    assign flush    = (l_state == L_LOAD) && dl_fall;
    assign drained  = fifo_empty && (d_state == D_IDLE) && !pend_valid && !push_valid && !hold_valid;

    assign dbg_loader_state = l_state;
    assign dbg_disp_state   = d_state;

    always_comb begin
        pair    = pend_valid && (pend_addr[24:1] == ioctl_addr[24:1]);
        stale_e = make_entry(pend_addr, GFX_BASE, 2'b01, {8'h00, pend_lo});
        new_e   = make_entry(ioctl_addr, GFX_BASE, pair ? 2'b11 : 2'b10,
                             {ioctl_dout, pair ? pend_lo : 8'h00});
    end

    // Assembler: a lone odd byte behind a stale pending byte needs two pushes,
    // so the second one waits one cycle in the hold register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_d       <= 1'b0;
            downl_d    <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_lo    <= '0;
            push_valid <= 1'b0;
            push_entry <= '0;
            hold_valid <= 1'b0;
            hold_entry <= '0;
        end else begin
            wr_d       <= ioctl_wr;
            downl_d    <= ioctl_downl;
            push_valid <= 1'b0;
            hold_valid <= 1'b0;
            if (hold_valid) begin
                push_valid <= 1'b1;
                push_entry <= hold_entry;
            end else if (accept) begin
                if (!ioctl_addr[0]) begin
                    push_valid <= pend_valid;
                    push_entry <= stale_e;
                    pend_valid <= 1'b1;
                    pend_addr  <= ioctl_addr;
                    pend_lo    <= ioctl_dout;
                end else begin
                    pend_valid <= 1'b0;
                    push_valid <= 1'b1;
                    if (pair || !pend_valid) begin
                        push_entry <= new_e;
                    end else begin
                        push_entry <= stale_e;
                        hold_valid <= 1'b1;
                        hold_entry <= new_e;
                    end
                end
            end else if (flush) begin
                push_valid <= pend_valid;
                push_entry <= stale_e;
                pend_valid <= 1'b0;
            end
        end
    end

    dl_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .wr_en   (push_valid),
        .wr_data (push_entry),
        .rd_en   (fifo_rd),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Port handshake: a write is issued by toggling portN_req with a/d/ds already
    // valid; the SDRAM completes it by making portN_ack equal to portN_req.
    assign fifo_rd  = (d_state == D_IDLE) && !fifo_empty;
    assign sel_idle = sel2 ? (port2_ack == port2_req) : (port1_ack == port1_req);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            d_state   <= D_IDLE;
            sel2      <= 1'b0;
            port1_req <= 1'b0;
            port1_a   <= '0;
            port1_ds  <= '0;
            port1_d   <= '0;
            port2_req <= 1'b0;
            port2_a   <= '0;
            port2_ds  <= '0;
            port2_d   <= '0;
        end else begin
            case (d_state)
                D_IDLE: if (!fifo_empty) begin
                    d_state <= D_WAIT;
                    sel2    <= head.port2;
                    if (head.port2) begin
                        port2_a   <= head.a;
                        port2_ds  <= head.ds;
                        port2_d   <= head.d;
                        port2_req <= ~port2_req;
                    end else begin
                        port1_a   <= head.a;
                        port1_ds  <= head.ds;
                        port1_d   <= head.d;
                        port1_req <= ~port1_req;
                    end
                end
                D_WAIT: if (sel_idle) d_state <= D_IDLE;
                default: d_state <= D_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            l_state    <= L_IDLE;
            rom_loaded <= 1'b0;
            overflow   <= 1'b0;
            port1_we   <= 1'b0;
            port2_we   <= 1'b0;
            core_reset <= 1'b1;
        end else begin
            core_reset <= ext_reset | ~rom_loaded;
            if (push_valid && fifo_full && !fifo_rd) overflow <= 1'b1;
            case (l_state)
                L_LOAD: if (dl_fall) l_state <= L_DRAIN;
                L_IDLE, L_DRAIN, L_DONE: begin
                    if (dl_rise) begin
                        l_state    <= L_LOAD;
                        rom_loaded <= 1'b0;
                        overflow   <= 1'b0;
                        port1_we   <= 1'b1;
                        port2_we   <= 1'b1;
                    end else if (l_state == L_DRAIN && drained) begin
                        l_state    <= L_DONE;
                        rom_loaded <= 1'b1;
                        port1_we   <= 1'b0;
                        port2_we   <= 1'b0;
                    end
                end
                default: l_state <= L_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rom_download_sdram_writer.md
# rom_download_sdram_writer

Sequencer between `data_io` and `sdram` that turns the byte-wide ROM download stream into 16-bit SDRAM word writes on the two toggle-handshake ports. Port 1 carries CPU ROM and port 2 carries graphics ROM. The block pairs adjacent bytes and buffers words while an SDRAM port is busy. It also produces `rom_loaded` and the core reset once every buffered write has landed.

## Interface
- `FIFO_DEPTH`, 4: word-write buffer entries, power of two.
- `GFX_BASE`, 25'h10000: first byte address routed to port 2.
- `ROM_INDEX`, 8'h00: `ioctl_index` value that is accepted; all other indices are ignored.

Ports:
- `clk_sys`  in  1  single clock; all `ioctl_*` and `port*` signals are in this domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ioctl_downl`  in  1  download active.
- `ioctl_wr`  in  1  byte strobe; the rising edge is taken.
- `ioctl_index`  in  8  download index.
- `ioctl_addr`  in  25  byte address.
- `ioctl_dout`  in  8  byte data.
- `ext_reset`  in  1  OSD or button reset request.
- `port1_req` / `port2_req`  out  1  toggle request.
- `port1_ack` / `port2_ack`  in  1  toggle acknowledge; the port is idle when ack == req.
- `port1_a` / `port2_a`  out  23  word address.
- `port1_ds` / `port2_ds`  out  2  byte enables, {hi, lo}.
- `port1_d` / `port2_d`  out  16  write data, {hi, lo}.
- `port1_we` / `port2_we`  out  1  write enable.
- `rom_loaded`  out  1  all ROM words written.
- `core_reset`  out  1  registered `ext_reset | ~rom_loaded`.
- `overflow`  out  1  sticky; a word was dropped because the FIFO was full.

## Operation
**Reset values:**
- `req`, `a`, `ds`, `d`, `we`, `rom_loaded`, `overflow` = 0.
- `core_reset` = 1.
- All FSMs in IDLE; FIFO empty; pending byte invalid.

**Accept:** a byte is accepted when a rising edge of `ioctl_wr` occurs while `ioctl_downl` = 1 and `ioctl_index` == `ROM_INDEX`.

**Assembler** (one pending even byte: `lo`, word address `wa`):
- Even byte: if a pending byte exists, push it alone (ds = 01) first. Then store the new byte as pending.
- Odd byte with pending and same `wa`: push `{byte, lo}` with ds = 11; pending is cleared.
- Odd byte otherwise: push any stale pending (ds = 01) first, then push the odd byte alone, `{byte, 8'h00}` with ds = 10.
- Back-to-back pushes: at most one push per cycle. A second push goes out on the next cycle. Bytes arrive at least 4 cycles apart, so there is no conflict.

**Routing** (decided at push):
- Byte address < `GFX_BASE`: port 1, `a` = `addr[23:1]`.
- Otherwise: port 2, `a` = `addr[23:1]` − `GFX_BASE[24:1]`, truncated to 23 bits.

**Overflow:** a push into a full FIFO is dropped and sets `overflow`. `overflow` clears on the next download start.

**Dispatcher FSM:**
- IDLE: if the FIFO is non-empty, pop the head, drive the selected port's `a`/`d`/`ds`, toggle its `req`, and go to WAIT.
- WAIT: when the selected port's ack == req, go to IDLE.
- Only one write is outstanding at a time across both ports.

**Loader FSM:**
- IDLE → LOAD on `ioctl_downl` rise with a matching index. On entry: clear `rom_loaded` and `overflow`, set both `we` = 1.
- LOAD → DRAIN on `ioctl_downl` fall. On entry: flush any pending byte (ds = 01).
- DRAIN → DONE when the FIFO is empty, the dispatcher is IDLE, and no pending byte remains. On entry: set `rom_loaded` = 1, set both `we` = 0.
- DONE → LOAD on a new matching download rise.
- A matching rise while in DRAIN → LOAD. Queued words are still written; `rom_loaded` stays 0.

**Other rules:**
- `core_reset` is registered every cycle.
- `reset_n` asserted mid-download: all state is lost immediately and any outstanding SDRAM toggle is abandoned.

## Timing
- Odd byte accepted at cycle t → FIFO write at t+1 → `req` toggles at t+2 (FIFO empty, dispatcher IDLE). `a`/`d`/`ds` are valid from t+2 and held until the next issue.
- FIFO: registered write, show-ahead read; full and empty flags are updated in the cycle after a push or pop.
- Ack toggling in the same cycle as `req` is ignored; ack is sampled from the cycle after issue.
- `rom_loaded` rises 1 cycle after the DRAIN exit condition; `core_reset` falls 1 cycle later if `ext_reset` = 0.
- Simultaneous push and pop on a full FIFO is allowed; nothing is dropped.

## Structure
- Package `rom_dl_pkg`:
  - `typedef enum {L_IDLE, L_LOAD, L_DRAIN, L_DONE}` for the loader FSM.
  - `typedef enum {D_IDLE, D_WAIT}` for the dispatcher FSM.
  - `typedef struct packed {logic port2; logic [22:0] a; logic [1:0] ds; logic [15:0] d;} wr_entry_t`.
- Sub-module `dl_word_fifo`: parameterised synchronous FIFO of `wr_entry_t`, with `full`/`empty`.

## Test plan
- Bytes 0xAA at address 0 and 0x55 at address 1; ack 3 cycles after req → one port-1 write, `a` = 0, `d` = 0x55AA, `ds` = 11; `req` toggles once.
- Byte at address 0x10004 then 0x10005 → port 2, `a` = 0x0002, `ds` = 11; `port1_req` is unchanged.
- Even byte 0x12 at address 6, then `ioctl_downl` falls → DRAIN flushes `d` = 0x0012, `ds` = 01; `rom_loaded` rises only after the ack; `core_reset` falls 1 cycle later.
- Ack withheld for 200 cycles while 12 bytes stream in (FIFO_DEPTH = 4) → `overflow` = 1; the first 5 words are delivered in order after ack resumes.
- Strobes with `ioctl_index` = 0xFF → no `req` toggles; `rom_loaded` is unchanged.
- `reset_n` pulled low in WAIT → all outputs return to reset values asynchronously, `core_reset` = 1; a new download proceeds normally.
